logo_bounce_engine: RTL and testbench
=====================================

Name: logo_bounce_engine

Overview:
- Consumes the horizontal/vertical pixel counts and the end-of-frame pulse from the screen counters.
- Once per frame, moves a rectangular logo across the 640x480 active area, reflecting it off the screen edges.
- Cycles the logo colour on every bounce.
- Produces the registered per-pixel RGB value that feeds the VGA output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CNT_W, 10, width of h_count/v_count and of the position registers
- LOGO_W, 64, logo width in pixels
- LOGO_H, 32, logo height in lines
- STEP, 2, pixels moved per axis per frame (1..15)
- X_INIT, 100, reset x position of the logo's top-left corner
- Y_INIT, 50, reset y position of the logo's top-left corner

Ports:
- clk  input  1  pixel clock (25 MHz)
- rst_n  input  1  asynchronous active-low reset
- frame_tick  input  1  one-cycle pulse once per frame, from the vertical counter's trigger output
- h_count  input  CNT_W  current horizontal count, 0..799
- v_count  input  CNT_W  current vertical count, 0..524
- pause  input  1  when high, position and direction are frozen
- rgb  output  12  registered pixel colour, 4:4:4
- pixel_on  output  1  registered flag: the current pixel is inside the logo
- logo_x  output  CNT_W  current logo left edge
- logo_y  output  CNT_W  current logo top edge
- bounce  output  1  one-cycle pulse on the cycle after any edge reflection

Behaviour:
- Reset (async, rst_n low):
  - logo_x=X_INIT, logo_y=Y_INIT
  - dir_x=+1, dir_y=+1
  - color_idx=0
  - rgb=0, pixel_on=0, bounce=0
- Reset mid-frame: all state returns to the reset values immediately; motion resumes at the first frame_tick after release.
- Motion update occurs only on a cycle where frame_tick=1 and pause=0; otherwise position, direction and colour hold.
- X axis, moving right (dir_x=+1):
  - if logo_x+STEP >= H_ACTIVE-LOGO_W: logo_x <= H_ACTIVE-LOGO_W (clamp), dir_x <= -1, x_hit
  - else logo_x <= logo_x+STEP
- X axis, moving left:
  - if logo_x <= STEP: logo_x <= 0, dir_x <= +1, x_hit
  - else logo_x <= logo_x-STEP
- Y axis: identical rules, using V_ACTIVE and LOGO_H.
- Comparisons use CNT_W+1 bits so there is no wrap-around.
- Bounce handling:
  - x_hit or y_hit: color_idx <= color_idx+1 (mod 8) and bounce pulses for 1 cycle.
  - Corner hit (both axes in the same update): colour advances once, a single bounce pulse, both directions flip.
- Pixel path, 1-cycle latency:
  - hit = h_count>=logo_x && h_count<logo_x+LOGO_W && v_count>=logo_y && v_count<logo_y+LOGO_H
  - active = h_count<H_ACTIVE && v_count<V_ACTIVE
  - Next cycle: pixel_on <= hit && active
  - rgb <= 0 when !active; PALETTE[color_idx] when hit; BG_COLOR otherwise.
  - The pixel path uses the pre-update position in the cycle frame_tick is high; the new position is seen from the next cycle.
  - Because frame_tick occurs during vertical blanking, no visible tearing occurs.
- pause=1 together with frame_tick: no update, no bounce pulse.
- Elaboration-time check:
  - X_INIT <= H_ACTIVE-LOGO_W, Y_INIT <= V_ACTIVE-LOGO_H, STEP>=1.
  - Violation halts simulation with $error.

Decomposition:
- Shared constants include (vga_defs):
  - H_ACTIVE/V_ACTIVE/H_TOTAL/V_TOTAL
  - BG_COLOR = 12'h000
  - PALETTE[0..7]: F00, 0F0, 00F, FF0, 0FF, F0F, FFF, F80
  - the direction encoding
- One natural sub-module: bounce_axis, instantiated twice (x and y).
  - Parameters: LIMIT, SIZE, STEP, INIT.
  - Ports: clk, rst_n, step_en, pos, hit.
  - Contains the position register, direction flag and clamp/reflect logic.
- Pixel compare and colour registers stay in the top level.

Test Plan:
- Reset then release, no ticks: logo_x=100, logo_y=50, rgb=0 in blanking. Scan (h=100,v=50) -> next cycle pixel_on=1, rgb=12'hF00. Scan (h=164,v=50) -> next cycle pixel_on=0, rgb=12'h000 (BG).
- 10 frame_ticks from reset -> logo_x=120, logo_y=70, bounce never asserted, color_idx=0.
- Right edge: force X_INIT=574, STEP=2 -> first tick logo_x=576, dir flips, bounce=1 for exactly 1 cycle, rgb of logo becomes 12'h0F0. Second tick -> logo_x=574.
- Corner: X_INIT=574, Y_INIT=446, LOGO_H=32, STEP=2 -> one tick gives logo_x=576, logo_y=448, single bounce pulse, color_idx=1.
- pause=1 held over 5 ticks -> position and colour unchanged, bounce stays 0. Release -> next tick moves by STEP.
- Assert rst_n low mid-line (h=300,v=200) with the logo displaced -> outputs return to reset values asynchronously within the same cycle. After release, first tick -> logo_x=102.

Source files
------------

// File: rtl/logo_bounce_engine_pkg.sv
// Shared VGA timing constants, logo colour table and direction encoding
// for the bouncing-logo engine.
package logo_bounce_engine_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;

  localparam logic [11:0] BG_COLOR = 12'h000;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  function automatic logic [11:0] palette_color(input logic [2:0] idx);
    palette_color = BG_COLOR;
    case (idx)
      3'd0: palette_color = 12'hF00;
      3'd1: palette_color = 12'h0F0;
      3'd2: palette_color = 12'h00F;
      3'd3: palette_color = 12'hFF0;
      3'd4: palette_color = 12'h0FF;
      3'd5: palette_color = 12'hF0F;
      3'd6: palette_color = 12'hFFF;
      3'd7: palette_color = 12'hF80;
      default: palette_color = BG_COLOR;
    endcase
  endfunction

endpackage

// File: rtl/logo_bounce_engine_if.sv
// Scan-count inputs and pixel/position outputs of the bounce engine;
// master drives the screen counts, slave is the engine. No backpressure.
interface logo_bounce_engine_if #(
  parameter int CNT_W = 10
);
  logic             frame_tick;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             pause;
  logic [11:0]      rgb;
  logic             pixel_on;
  logic [CNT_W-1:0] logo_x;
  logic [CNT_W-1:0] logo_y;
  logic             bounce;

  modport master (
    output frame_tick, h_count, v_count, pause,
    input  rgb, pixel_on, logo_x, logo_y, bounce
  );

  modport slave (
    input  frame_tick, h_count, v_count, pause,
    output rgb, pixel_on, logo_x, logo_y, bounce
  );
endinterface

// File: rtl/logo_bounce_engine_bounce_axis.sv
// One axis of logo motion: position register, direction flag, clamp/reflect.
// Position updates on the step_en edge; hit is combinational and flags a reflection on that step.
module bounce_axis
  import logo_bounce_engine_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int LIMIT = 640,
  parameter int SIZE  = 64,
  parameter int STEP  = 2,
  parameter int INIT  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  output logic [CNT_W-1:0] pos,
  output logic             hit
);

  // One extra bit keeps pos+STEP from wrapping near the far edge.
  localparam logic [CNT_W:0] MAX_W  = (CNT_W+1)'(LIMIT - SIZE);
  localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);

  dir_e           dir;
  logic [CNT_W:0] pos_w;
  logic [CNT_W:0] fwd_sum;
  logic           edge_hit;

  always_comb begin
    pos_w    = {1'b0, pos};
    fwd_sum  = pos_w + STEP_W;
    edge_hit = (dir == DIR_POS) ? (fwd_sum >= MAX_W) : (pos_w <= STEP_W);
    hit      = step_en & edge_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= CNT_W'(INIT);
      dir <= DIR_POS;
    end else if (step_en) begin
      if (dir == DIR_POS) begin
        if (edge_hit) begin
          pos <= MAX_W[CNT_W-1:0];
          dir <= DIR_NEG;
        end else begin
          pos <= fwd_sum[CNT_W-1:0];
        end
      end else begin
        if (edge_hit) begin
          pos <= '0;
          dir <= DIR_POS;
        end else begin
          pos <= pos - STEP_W[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/logo_bounce_engine.sv
// Bouncing logo: per-frame motion with colour change on each bounce, plus registered pixel colour.
// Pixel path has 1-cycle latency; no backpressure, one pixel accepted every clock.
module logo_bounce_engine
  import logo_bounce_engine_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int CNT_W    = 10,
  parameter int LOGO_W   = 64,
  parameter int LOGO_H   = 32,
  parameter int STEP     = 2,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 50
) (
  input logic                 clk,
  input logic                 rst_n,
  logo_bounce_engine_if.slave bus
);

  if (X_INIT > H_ACTIVE - LOGO_W || Y_INIT > V_ACTIVE - LOGO_H || STEP < 1) begin : g_param_check
    $error("logo_bounce_engine: initial position off-screen or STEP < 1");
  end

  localparam logic [CNT_W:0] H_ACT_W  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT_W  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] LOGO_W_W = (CNT_W+1)'(LOGO_W);
  localparam logic [CNT_W:0] LOGO_H_W = (CNT_W+1)'(LOGO_H);

  logic             step_en;
  logic             x_hit;
  logic             y_hit;
  logic [CNT_W-1:0] logo_x;
  logic [CNT_W-1:0] logo_y;
  logic [2:0]       color_idx;
  logic             bounce_q;
  logic             pixel_on_q;
  logic [11:0]      rgb_q;

  assign step_en = bus.frame_tick & ~bus.pause;

  bounce_axis #(
    .CNT_W (CNT_W),
    .LIMIT (H_ACTIVE),
    .SIZE  (LOGO_W),
    .STEP  (STEP),
    .INIT  (X_INIT)
  ) u_axis_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (step_en),
    .pos     (logo_x),
    .hit     (x_hit)
  );

  bounce_axis #(
    .CNT_W (CNT_W),
    .LIMIT (V_ACTIVE),
    .SIZE  (LOGO_H),
    .STEP  (STEP),
    .INIT  (Y_INIT)
  ) u_axis_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (step_en),
    .pos     (logo_y),
    .hit     (y_hit)
  );

  // A corner hit still advances the colour once and gives a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_idx <= 3'd0;
      bounce_q  <= 1'b0;
    end else begin
      bounce_q <= x_hit | y_hit;
      if (x_hit | y_hit) begin
        color_idx <= color_idx + 3'd1;
      end
    end
  end

  logic [CNT_W:0] h_w;
  logic [CNT_W:0] v_w;
  logic           in_logo;
  logic           active;

  always_comb begin
    h_w     = {1'b0, bus.h_count};
    v_w     = {1'b0, bus.v_count};
    in_logo = (h_w >= {1'b0, logo_x}) && (h_w < {1'b0, logo_x} + LOGO_W_W) &&
              (v_w >= {1'b0, logo_y}) && (v_w < {1'b0, logo_y} + LOGO_H_W);
    active  = (h_w < H_ACT_W) && (v_w < V_ACT_W);
  end

  // Position seen here is the pre-update one during the frame_tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on_q <= 1'b0;
      rgb_q      <= 12'h000;
    end else begin
      pixel_on_q <= in_logo & active;
      if (!active) begin
        rgb_q <= 12'h000;
      end else if (in_logo) begin
        rgb_q <= palette_color(color_idx);
      end else begin
        rgb_q <= BG_COLOR;
      end
    end
  end

  assign bus.logo_x   = logo_x;
  assign bus.logo_y   = logo_y;
  assign bus.bounce   = bounce_q;
  assign bus.pixel_on = pixel_on_q;
  assign bus.rgb      = rgb_q;

endmodule

// File: tb/tb_logo_bounce_engine.sv
// Directed bench: default engine plus right-edge and corner variants, checked with immediate assertions.
module tb_logo_bounce_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h;
  logic [9:0] v;
  logic       pause;
  logic       tick_a;
  logic       tick_b;
  logic       tick_c;

  int vectors = 0;
  int miscompares = 0;

  always #20 clk = ~clk;

  logo_bounce_engine_if #(.CNT_W(10)) ifa ();
  logo_bounce_engine_if #(.CNT_W(10)) ifb ();
  logo_bounce_engine_if #(.CNT_W(10)) ifc ();

  assign ifa.h_count = h;
  assign ifa.v_count = v;
  assign ifa.pause   = pause;
  assign ifa.frame_tick = tick_a;
  assign ifb.h_count = h;
  assign ifb.v_count = v;
  assign ifb.pause   = pause;
  assign ifb.frame_tick = tick_b;
  assign ifc.h_count = h;
  assign ifc.v_count = v;
  assign ifc.pause   = pause;
  assign ifc.frame_tick = tick_c;

  logo_bounce_engine dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  logo_bounce_engine #(.X_INIT(574)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  logo_bounce_engine #(.X_INIT(574), .Y_INIT(446), .LOGO_H(32), .STEP(2)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a scan position and wait until the registered result is visible.
  task automatic scan(input logic [9:0] hh, input logic [9:0] vv);
    h = hh;
    v = vv;
    @(negedge clk);
  endtask

  // One-cycle frame_tick on the selected engine (0=a, 1=b, 2=c).
  task automatic tick(input int which);
    tick_a = (which == 0);
    tick_b = (which == 1);
    tick_c = (which == 2);
    @(negedge clk);
    tick_a = 1'b0;
    tick_b = 1'b0;
    tick_c = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    h      = 10'd700;
    v      = 10'd500;
    pause  = 1'b0;
    tick_a = 1'b0;
    tick_b = 1'b0;
    tick_c = 1'b0;
    @(negedge clk);
    chk("rst_logo_x", ifa.logo_x, 100);
    chk("rst_logo_y", ifa.logo_y, 50);
    chk("rst_rgb", ifa.rgb, 12'h000);
    chk("rst_pixel_on", ifa.pixel_on, 0);
    chk("rst_bounce", ifa.bounce, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("blank_rgb", ifa.rgb, 12'h000);
    chk("idle_logo_x", ifa.logo_x, 100);

    scan(10'd100, 10'd50);
    chk("tl_pixel_on", ifa.pixel_on, 1);
    chk("tl_rgb", ifa.rgb, 12'hF00);
    scan(10'd164, 10'd50);
    chk("right_out_pixel_on", ifa.pixel_on, 0);
    chk("right_out_rgb", ifa.rgb, 12'h000);
    scan(10'd163, 10'd81);
    chk("br_in_pixel_on", ifa.pixel_on, 1);
    scan(10'd100, 10'd82);
    chk("below_pixel_on", ifa.pixel_on, 0);
    scan(10'd700, 10'd50);
    chk("hblank_pixel_on", ifa.pixel_on, 0);

    for (int i = 0; i < 10; i++) begin
      tick(0);
      chk("run_bounce", ifa.bounce, 0);
    end
    chk("run_logo_x", ifa.logo_x, 120);
    chk("run_logo_y", ifa.logo_y, 70);
    scan(10'd120, 10'd70);
    chk("run_color", ifa.rgb, 12'hF00);
    chk("run_old_pos_out", 32'(dut_a.pixel_on_q), 1);

    tick(1);
    chk("edge_logo_x", ifb.logo_x, 576);
    chk("edge_logo_y", ifb.logo_y, 52);
    chk("edge_bounce", ifb.bounce, 1);
    scan(10'd576, 10'd52);
    chk("edge_bounce_1cyc", ifb.bounce, 0);
    chk("edge_pixel_on", ifb.pixel_on, 1);
    chk("edge_rgb", ifb.rgb, 12'h0F0);
    tick(1);
    chk("edge_back_x", ifb.logo_x, 574);
    chk("edge_back_bounce", ifb.bounce, 0);

    tick(2);
    chk("corner_logo_x", ifc.logo_x, 576);
    chk("corner_logo_y", ifc.logo_y, 448);
    chk("corner_bounce", ifc.bounce, 1);
    scan(10'd576, 10'd448);
    chk("corner_single_pulse", ifc.bounce, 0);
    chk("corner_rgb", ifc.rgb, 12'h0F0);

    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(0);
      chk("pause_bounce", ifa.bounce, 0);
    end
    chk("pause_logo_x", ifa.logo_x, 120);
    chk("pause_logo_y", ifa.logo_y, 70);
    scan(10'd120, 10'd70);
    chk("pause_rgb", ifa.rgb, 12'hF00);
    pause = 1'b0;
    tick(0);
    chk("resume_logo_x", ifa.logo_x, 122);
    chk("resume_logo_y", ifa.logo_y, 72);

    scan(10'd130, 10'd80);
    chk("pre_rst_pixel_on", ifa.pixel_on, 1);
    h = 10'd300;
    v = 10'd200;
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_logo_x", ifa.logo_x, 100);
    chk("async_logo_y", ifa.logo_y, 50);
    chk("async_pixel_on", ifa.pixel_on, 0);
    chk("async_rgb", ifa.rgb, 12'h000);
    chk("async_b_logo_x", ifb.logo_x, 574);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick(0);
    chk("post_rst_logo_x", ifa.logo_x, 102);
    chk("post_rst_logo_y", ifa.logo_y, 52);
    chk("post_rst_bounce", ifa.bounce, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
